score_pair_feeder: RTL and testbench

//  Producer side of the pairwise argmax interface. On START, reads N_SCORES signed output-layer

---
 rtl/score_pair_feeder.sv | 183 ++++++++++++++++++
 tb/tb_score_pair_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_pair_feeder.sv
// ---------------------------------------------------------------------------
// score_pair_feeder
//
// Producer side of a pairwise argmax interface. On START it clears the
// comparator, reads N_SCORES signed scores from a synchronous-read score RAM
// and presents them two at a time (COMP_IN1/COMP_IN2) with a one-cycle
// COMP_TRIG strobe. A missing second score of an odd final pair is replaced
// by PAD_VAL. DONE pulses for one cycle once the comparator result is final.
//
// Ports
//   CLKEXT     in   1       clock, rising edge
//   RST_FEED   in   1       asynchronous active-high reset
//   START      in   1       scan request, accepted from IDLE only
//   BUSY       out  1       high from CLEAR through the last EMIT
//   DONE       out  1       one-cycle completion pulse
//   SC_RE      out  1       score RAM read enable
//   SC_ADDR    out  ADDR_W  score RAM read address
//   SC_RDATA   in   DATA_W  score RAM data, valid the cycle after SC_RE
//   COMP_RST   out  1       comparator clear, high during CLEAR
//   COMP_EN    out  1       comparator enable, equals BUSY
//   COMP_TRIG  out  1       pair strobe, high during EMIT
//   COMP_IN1   out  DATA_W  even-index score of the current pair
//   COMP_IN2   out  DATA_W  odd-index score or PAD_VAL
// ---------------------------------------------------------------------------
module score_pair_feeder #(
    parameter int                  N_SCORES = 10,
    parameter int                  DATA_W   = 16,
    parameter int                  ADDR_W   = 4,
    parameter logic [DATA_W-1:0]   PAD_VAL  = {1'b1, {(DATA_W-1){1'b0}}}
) (
    input  logic              CLKEXT,
    input  logic              RST_FEED,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              SC_RE,
    output logic [ADDR_W-1:0] SC_ADDR,
    input  logic [DATA_W-1:0] SC_RDATA,
    output logic              COMP_RST,
    output logic              COMP_EN,
    output logic              COMP_TRIG,
    output logic [DATA_W-1:0] COMP_IN1,
    output logic [DATA_W-1:0] COMP_IN2
);

    localparam int N_PAIRS = (N_SCORES + 1) / 2;
    localparam int PW      = $clog2(N_PAIRS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD_A,
        S_RD_B,
        S_CAP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pair_q, pair_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   in1_q, in1_d;
    logic [DATA_W-1:0]   in2_q, in2_d;

    // Index of the first score of the current pair, and the pair shape tests
    logic [31:0]         idx_a;
    logic                has_b;
    logic                last_pair;

    assign idx_a     = 32'(pair_q) << 1;
    assign has_b     = (idx_a + 32'd1) < 32'(N_SCORES);
    assign last_pair = (idx_a + 32'd2) >= 32'(N_SCORES);

    // State register
    always_ff @(posedge CLKEXT or posedge RST_FEED) begin
        if (RST_FEED) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_CLEAR;
            S_CLEAR: state_d = S_RD_A;
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = S_CAP;
            S_CAP:   state_d = S_EMIT;
            S_EMIT:  state_d = last_pair ? S_DONE : S_RD_A;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic (Moore)
    always_comb begin
        BUSY      = 1'b0;
        DONE      = 1'b0;
        SC_RE     = 1'b0;
        COMP_RST  = 1'b0;
        COMP_TRIG = 1'b0;
        case (state_q)
            S_CLEAR: begin
                BUSY     = 1'b1;
                COMP_RST = 1'b1;
            end
            S_RD_A: begin
                BUSY  = 1'b1;
                SC_RE = 1'b1;
            end
            S_RD_B: begin
                BUSY  = 1'b1;
                SC_RE = has_b;
            end
            S_CAP: begin
                BUSY = 1'b1;
            end
            S_EMIT: begin
                BUSY      = 1'b1;
                COMP_TRIG = 1'b1;
            end
            S_DONE: begin
                DONE = 1'b1;
            end
            default: ;
        endcase
        COMP_EN = BUSY;
    end

    // Datapath next-state. SC_ADDR is registered, so the address for a read
    // state is loaded on entry to it: 2p on entering RD_A (from CLEAR or EMIT)
    // and 2p+1 on entering RD_B when that score exists.
    always_comb begin
        pair_d = pair_q;
        addr_d = addr_q;
        in1_d  = in1_q;
        in2_d  = in2_q;
        case (state_q)
            S_CLEAR: begin
                pair_d = '0;
                addr_d = '0;
            end
            S_RD_A: begin
                if (has_b) addr_d = ADDR_W'(idx_a + 32'd1);
            end
            S_RD_B: begin
                in1_d = SC_RDATA;
            end
            S_CAP: begin
                in2_d = has_b ? SC_RDATA : PAD_VAL;
            end
            S_EMIT: begin
                if (!last_pair) begin
                    pair_d = pair_q + PW'(1);
                    addr_d = ADDR_W'(idx_a + 32'd2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKEXT or posedge RST_FEED) begin
        if (RST_FEED) begin
            pair_q <= '0;
            addr_q <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
        end else begin
            pair_q <= pair_d;
            addr_q <= addr_d;
            in1_q  <= in1_d;
            in2_q  <= in2_d;
        end
    end

    assign SC_ADDR  = addr_q;
    assign COMP_IN1 = in1_q;
    assign COMP_IN2 = in2_q;

endmodule

// File: tb/tb_score_pair_feeder.sv
// ---------------------------------------------------------------------------
// tb_score_pair_feeder
//
// Three feeder instances (N_SCORES = 10, 5, 1) share clock and reset. The
// bench provides a synchronous-read score RAM per instance and a behavioural
// argmax comparator (strict >, clear to most-negative value / index 0).
// ---------------------------------------------------------------------------
module tb_score_pair_feeder;

    localparam int NS [3] = '{10, 5, 1};

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        start;
    logic [2:0]        busy, done, re, crst, cen, trig;
    logic [3:0]        addr [3];
    logic [15:0]       in1  [3];
    logic [15:0]       in2  [3];
    logic [15:0]       mem  [3][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] rd;

        score_pair_feeder #(
            .N_SCORES (NS[g]),
            .DATA_W   (16),
            .ADDR_W   (4),
            .PAD_VAL  (16'h8000)
        ) u_dut (
            .CLKEXT    (clk),
            .RST_FEED  (rst),
            .START     (start[g]),
            .BUSY      (busy[g]),
            .DONE      (done[g]),
            .SC_RE     (re[g]),
            .SC_ADDR   (addr[g]),
            .SC_RDATA  (rd),
            .COMP_RST  (crst[g]),
            .COMP_EN   (cen[g]),
            .COMP_TRIG (trig[g]),
            .COMP_IN1  (in1[g]),
            .COMP_IN2  (in2[g])
        );

        always @(posedge clk) if (re[g]) rd <= mem[g][addr[g]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scan observation results
    int          r_done, r_trigs, r_addr_bad, r_b2b, r_rst_cnt, r_rst_bad, r_en_bad;
    logic [15:0] r_lg;
    int          r_ix;
    logic [15:0] r_l1, r_l2;
    logic [15:0] log1 [8];
    logic [15:0] log2 [8];

    // Pulse START (or hold it high throughout) and watch one scan at negedges.
    // Cycle 0 is the START cycle. Returns early right after the abort_trig-th TRIG.
    task automatic run_scan(input int sel, input int n, input bit hold, input int abort_trig);
        logic [15:0] m_lg;
        int          m_ix;
        bit          prev;
        r_done = 0; r_trigs = 0; r_addr_bad = 0; r_b2b = 0;
        r_rst_cnt = 0; r_rst_bad = 0; r_en_bad = 0;
        r_l1 = '0; r_l2 = '0; r_lg = '0; r_ix = -1;
        m_lg = 16'h8000; m_ix = 0; prev = 1'b0;
        @(negedge clk);
        start[sel] = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start[sel] = hold;
            if (crst[sel]) begin
                r_rst_cnt++;
                if (c != 1) r_rst_bad++;
                m_lg = 16'h8000;
                m_ix = 0;
            end
            if (busy[sel] !== cen[sel]) r_en_bad++;
            if (re[sel] && (int'(addr[sel]) >= n)) r_addr_bad++;
            if (trig[sel]) begin
                if (prev) r_b2b++;
                if (r_trigs < 8) begin
                    log1[r_trigs] = in1[sel];
                    log2[r_trigs] = in2[sel];
                end
                r_l1 = in1[sel];
                r_l2 = in2[sel];
                if ($signed(in1[sel]) > $signed(m_lg)) begin
                    m_lg = in1[sel];
                    m_ix = 2 * r_trigs + 1;
                end
                if ($signed(in2[sel]) > $signed(m_lg)) begin
                    m_lg = in2[sel];
                    m_ix = 2 * r_trigs + 2;
                end
                r_trigs++;
                if (r_trigs == abort_trig) return;
            end
            prev = trig[sel];
            if (done[sel]) begin
                r_done = c;
                r_lg   = m_lg;
                r_ix   = m_ix;
                break;
            end
        end
    endtask

    task automatic load_mem(input int sel, input int n, input logic [15:0] sc [10]);
        for (int j = 0; j < 16; j++)
            mem[sel][j] = (j < n) ? sc[j] : 16'h7FFF;
    endtask

    typedef struct {
        int          sel;
        int          n;
        logic [15:0] sc [10];
        int          exp_done;
        int          exp_trigs;
        logic [15:0] exp_lg;
        int          exp_ix;
        logic [15:0] exp_l1;
        logic [15:0] exp_l2;
    } vec_t;

    vec_t        vt [4];
    logic [15:0] t1_sc [10];
    logic [15:0] exp_p1 [5];
    logic [15:0] exp_p2 [5];
    int          cnt_done, cnt_busy;

    initial begin
        t1_sc  = '{16'h0005, 16'hFFFD, 16'h0007, 16'h0002, 16'h0007,
                   16'h0000, 16'hFFFF, 16'h0009, 16'h0004, 16'h0008};
        exp_p1 = '{16'h0005, 16'h0007, 16'h0007, 16'hFFFF, 16'h0004};
        exp_p2 = '{16'hFFFD, 16'h0002, 16'h0000, 16'h0009, 16'h0008};

        vt[0].sel = 0; vt[0].n = 10; vt[0].sc = t1_sc;
        vt[0].exp_done = 22; vt[0].exp_trigs = 5; vt[0].exp_lg = 16'h0009; vt[0].exp_ix = 8;
        vt[0].exp_l1 = 16'h0004; vt[0].exp_l2 = 16'h0008;

        vt[1].sel = 1; vt[1].n = 5;
        vt[1].sc = '{16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFEC,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vt[1].exp_done = 14; vt[1].exp_trigs = 3; vt[1].exp_lg = 16'hFFFB; vt[1].exp_ix = 4;
        vt[1].exp_l1 = 16'hFFEC; vt[1].exp_l2 = 16'h8000;

        vt[2].sel = 2; vt[2].n = 1;
        vt[2].sc = '{16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vt[2].exp_done = 6; vt[2].exp_trigs = 1; vt[2].exp_lg = 16'h8001; vt[2].exp_ix = 1;
        vt[2].exp_l1 = 16'h8001; vt[2].exp_l2 = 16'h8000;

        vt[3].sel = 0; vt[3].n = 10;
        for (int j = 0; j < 10; j++) vt[3].sc[j] = 16'h8000;
        vt[3].exp_done = 22; vt[3].exp_trigs = 5; vt[3].exp_lg = 16'h8000; vt[3].exp_ix = 0;
        vt[3].exp_l1 = 16'h8000; vt[3].exp_l2 = 16'h8000;

        // Reset state
        rst   = 1'b1;
        start = '0;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 16; j++) mem[s][j] = 16'h0000;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_ctl[%0d]", s),
                {26'd0, busy[s], done[s], re[s], crst[s], cen[s], trig[s]}, 32'd0);
            chk($sformatf("reset_data[%0d]", s), {in1[s], in2[s]} | {28'd0, addr[s]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Table-driven scans
        for (int i = 0; i < 4; i++) begin
            load_mem(vt[i].sel, vt[i].n, vt[i].sc);
            run_scan(vt[i].sel, vt[i].n, 1'b0, 0);
            chk($sformatf("v%0d_done_cycle", i), r_done,     vt[i].exp_done);
            chk($sformatf("v%0d_trigs", i),      r_trigs,    vt[i].exp_trigs);
            chk($sformatf("v%0d_largest", i),    r_lg,       vt[i].exp_lg);
            chk($sformatf("v%0d_index", i),      r_ix,       vt[i].exp_ix);
            chk($sformatf("v%0d_last_in1", i),   r_l1,       vt[i].exp_l1);
            chk($sformatf("v%0d_last_in2", i),   r_l2,       vt[i].exp_l2);
            chk($sformatf("v%0d_addr_range", i), r_addr_bad, 0);
            chk($sformatf("v%0d_trig_b2b", i),   r_b2b,      0);
            chk($sformatf("v%0d_clear_once", i), r_rst_cnt + 10 * r_rst_bad, 1);
            chk($sformatf("v%0d_en_eq_busy", i), r_en_bad,   0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {busy[vt[i].sel], done[vt[i].sel]}, 0);
            chk($sformatf("v%0d_hold_in", i), {in1[vt[i].sel], in2[vt[i].sel]},
                {vt[i].exp_l1, vt[i].exp_l2});
        end

        // START held high through the whole scan and into the DONE cycle
        load_mem(0, 10, t1_sc);
        run_scan(0, 10, 1'b1, 0);
        chk("hold_done_cycle", r_done,  22);
        chk("hold_trigs",      r_trigs, 5);
        chk("hold_result",     {r_lg, 16'(r_ix)}, {16'h0009, 16'd8});
        chk("hold_clear_once", r_rst_cnt, 1);
        @(negedge clk);
        start[0] = 1'b0;
        chk("start_in_done_ignored", {busy[0], crst[0], done[0]}, 0);
        repeat (2) @(negedge clk);
        chk("still_idle", busy[0], 0);
        run_scan(0, 10, 1'b0, 0);
        chk("rescan_from_idle", r_done, 22);

        // Reset during the second EMIT, then a full rescan
        run_scan(0, 10, 1'b0, 2);
        chk("abort_at_trig2", {r_trigs, 31'd0} | {31'd0, trig[0]}, {2, 31'd0} | 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ctl_zero", {busy[0], done[0], re[0], crst[0], cen[0], trig[0]}, 0);
        chk("abort_data_zero", {in1[0], in2[0]} | {28'd0, addr[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done[0]) cnt_done++;
            if (busy[0]) cnt_busy++;
        end
        chk("abort_no_done", {cnt_done, cnt_busy} != 0, 0);
        run_scan(0, 10, 1'b0, 0);
        chk("after_abort_done",    r_done, 22);
        chk("after_abort_result",  {r_lg, 16'(r_ix)}, {16'h0009, 16'd8});
        for (int k = 0; k < 5; k++)
            chk($sformatf("after_abort_pair%0d", k), {log1[k], log2[k]}, {exp_p1[k], exp_p2[k]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
